fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage.
- After reset it streams a program image from a loader into the instruction cache write port, then forces the PC to the boot address.
- It then drives PC enable, fetch enable, PC source select and flush to the fetch stage from stall, branch-redirect and halt requests.
- Sits between the hazard/branch-resolution logic and the fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded when boot completes.
- LOAD_BASE, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 1024, instruction-cache capacity in words.
- FLUSH_CYCLES, 1, bubbles injected after a taken branch (legal range 1-3).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ld_valid_i  in  1  loader word valid
- ld_data_i  in  32  loader instruction word
- ld_last_i  in  1  marks the final word of the image
- ld_ready_o  out  1  controller accepts a loader word
- stall_i  in  1  hazard-unit stall request
- branch_taken_i  in  1  branch/jump resolved taken
- branch_target_i  in  32  redirect target
- halt_i  in  1  stop fetching; sticky until reset
- pc_en_o  out  1  PC register update enable
- if_en_o  out  1  fetch-output update enable
- pc_src_o  out  1  0 = PC+4, 1 = branch_pc_o
- branch_pc_o  out  32  redirect PC
- flush_o  out  1  zero the fetched instruction
- wr_instr_en_o  out  1  cache write enable
- wr_instr_o  out  32  cache write data
- wr_addr_o  out  32  cache write byte address
- boot_done_o  out  1  high from first RUN cycle onward
- load_err_o  out  1  sticky image-overflow flag

Behaviour:
- Reset values: all outputs 0, except:
  - ld_ready_o = 1
  - wr_addr_o = LOAD_BASE
- Reset also sets state LOAD and word count 0. Reset mid-operation behaves identically: the image reload restarts at LOAD_BASE.
- State LOAD:
  - ld_ready_o = 1.
  - When ld_valid_i & ld_ready_o, the same cycle drives wr_instr_en_o = 1, wr_instr_o = ld_data_i, wr_addr_o = current address.
  - Next cycle: address += 4 and count += 1.
  - pc_en_o, if_en_o = 0 and flush_o = 1 throughout LOAD.
  - If the accepted word has ld_last_i set, go to START.
  - A word presented when count == MAX_WORDS is dropped (wr_instr_en_o = 0) and load_err_o is set.
  - The state still advances on ld_last_i.
- State START (exactly 1 cycle):
  - ld_ready_o = 0, pc_en_o = 1, pc_src_o = 1, branch_pc_o = RESET_PC, flush_o = 1.
  - Next state RUN.
- State RUN:
  - boot_done_o = 1 from the first RUN cycle onward.
  - Default: pc_en_o = if_en_o = !stall_i, pc_src_o = 0.
  - branch_taken_i = 1 in a RUN cycle:
    - That cycle drives pc_en_o = 1 (overrides stall), pc_src_o = 1, branch_pc_o = branch_target_i, flush_o = 1.
    - Load flush counter with FLUSH_CYCLES-1 and go to FLUSH when it is nonzero.
  - branch_target_i bits [1:0] are ignored and forced to 0 on branch_pc_o.
- State FLUSH:
  - flush_o = 1, pc_en_o = if_en_o = !stall_i, pc_src_o = 0.
  - Counter decrements only on non-stalled cycles; return to RUN at 0.
  - A new branch_taken_i in FLUSH restarts the redirect exactly as in RUN and reloads the counter.
- State HALT:
  - Entered from RUN or FLUSH when halt_i = 1; halt has priority over branch in the same cycle (the branch is ignored).
  - pc_en_o = if_en_o = 0, flush_o = 1. Exit only via reset.
- halt_i, stall_i and branch_taken_i are ignored in LOAD and START.
- Latency: a branch asserted in cycle N redirects the PC at the edge ending cycle N. The first target instruction is visible in cycle N+FLUSH_CYCLES if there are no stalls.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum: LOAD, START, RUN, FLUSH, HALT.
  - INSTR_W = 32, NOP_INSTR = 32'h0000_0013.
  - The PC increment constant, 4.
- Optional sub-module boot_loader_wr: the LOAD-state address/count/overflow datapath (one address register, one counter). Everything else is a single FSM in fetch_ctrl.

Test Plan:
- Reset, then load 3 words 0x00500093, 0x00100113, 0x002081B3 with ld_last_i on the third:
  - Writes go to addresses 0x0, 0x4, 0x8, each with wr_instr_en_o pulsed.
  - START cycle shows pc_src_o = 1, branch_pc_o = RESET_PC.
  - boot_done_o rises the next cycle.
- MAX_WORDS = 4, stream 6 words:
  - Words 5-6 are not written and load_err_o stays 1.
  - FSM reaches START after the word marked ld_last_i.
- In RUN, stall_i high for 3 cycles: pc_en_o = if_en_o = 0 for exactly those 3 cycles, flush_o = 0.
- FLUSH_CYCLES = 2, branch_taken_i with target 0x0000_0103 while stall_i = 1:
  - pc_en_o = 1, branch_pc_o = 0x0000_0100, flush_o high 2 unstalled cycles.
- halt_i and branch_taken_i asserted together in RUN:
  - HALT entered, branch_pc_o not used (pc_src_o = 0), pc_en_o stays 0 until rst_i.
- rst_i asserted mid-load after 2 words:
  - Next cycle ld_ready_o = 1, wr_addr_o = LOAD_BASE, boot_done_o = 0, load_err_o = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {LOAD, START, RUN, FLUSH, HALT} fetch_state_t;

  localparam int unsigned       INSTR_W   = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0]       PC_INC    = 32'd4;

endpackage

// File: rtl/boot_loader_wr.sv
// rtl/boot_loader_wr.sv - image load address/count datapath driving the icache write port
module boot_loader_wr
  import fetch_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               accept_i,
  input  logic [INSTR_W-1:0] data_i,
  output logic               wr_en_o,
  output logic [INSTR_W-1:0] wr_instr_o,
  output logic [31:0]        wr_addr_o,
  output logic               load_err_o
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          full;

  assign full = (cnt_q == CW'(MAX_WORDS));

  // Dropped words leave the address where it is; only the error flag records them.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (accept_i) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        addr_d = addr_q + PC_INC;
        cnt_d  = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= LOAD_BASE;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign wr_en_o    = accept_i & ~full;
  assign wr_instr_o = wr_en_o ? data_i : '0;
  assign wr_addr_o  = rst_i ? LOAD_BASE : addr_q;
  assign load_err_o = err_q & ~rst_i;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - boot-load then stall/branch/halt sequencing for the fetch stage
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] LOAD_BASE    = 32'h0000_0000,
  parameter int unsigned MAX_WORDS    = 1024,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ld_valid_i,
  input  logic [INSTR_W-1:0] ld_data_i,
  input  logic               ld_last_i,
  output logic               ld_ready_o,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [31:0]        branch_target_i,
  input  logic               halt_i,
  output logic               pc_en_o,
  output logic               if_en_o,
  output logic               pc_src_o,
  output logic [31:0]        branch_pc_o,
  output logic               flush_o,
  output logic               wr_instr_en_o,
  output logic [INSTR_W-1:0] wr_instr_o,
  output logic [31:0]        wr_addr_o,
  output logic               boot_done_o,
  output logic               load_err_o
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  fetch_state_t state_q, state_d;
  logic [1:0]   fcnt_q, fcnt_d;
  logic         accept;
  logic         unused_tgt_bits;

  assign unused_tgt_bits = ^branch_target_i[1:0];
  assign accept = ld_valid_i & (state_q == LOAD) & ~rst_i;

  boot_loader_wr #(
    .LOAD_BASE (LOAD_BASE),
    .MAX_WORDS (MAX_WORDS)
  ) u_loader (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .accept_i   (accept),
    .data_i     (ld_data_i),
    .wr_en_o    (wr_instr_en_o),
    .wr_instr_o (wr_instr_o),
    .wr_addr_o  (wr_addr_o),
    .load_err_o (load_err_o)
  );

  // While reset is held, outputs sit at their quiescent values regardless of state.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    ld_ready_o  = 1'b0;
    pc_en_o     = 1'b0;
    if_en_o     = 1'b0;
    pc_src_o    = 1'b0;
    branch_pc_o = '0;
    flush_o     = 1'b0;
    boot_done_o = 1'b0;
    if (rst_i) begin
      ld_ready_o = 1'b1;
    end else begin
      unique case (state_q)
        LOAD: begin
          ld_ready_o = 1'b1;
          flush_o    = 1'b1;
          if (accept && ld_last_i) state_d = START;
        end
        START: begin
          pc_en_o     = 1'b1;
          pc_src_o    = 1'b1;
          branch_pc_o = RESET_PC;
          flush_o     = 1'b1;
          state_d     = RUN;
        end
        RUN, FLUSH: begin
          boot_done_o = 1'b1;
          pc_en_o     = ~stall_i;
          if_en_o     = ~stall_i;
          flush_o     = (state_q == FLUSH);
          if (halt_i) begin
            pc_en_o = 1'b0;
            if_en_o = 1'b0;
            flush_o = 1'b1;
            state_d = HALT;
          end else if (branch_taken_i) begin
            pc_en_o     = 1'b1;
            pc_src_o    = 1'b1;
            branch_pc_o = {branch_target_i[31:2], 2'b00};
            flush_o     = 1'b1;
            fcnt_d      = FLUSH_LOAD;
            state_d     = (FLUSH_LOAD != 2'd0) ? FLUSH : RUN;
          end else if (state_q == FLUSH && !stall_i) begin
            fcnt_d = fcnt_q - 2'd1;
            if (fcnt_q == 2'd1) state_d = RUN;
          end
        end
        HALT: begin
          boot_done_o = 1'b1;
          flush_o     = 1'b1;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule
